// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative 64-bit restoring divider for DIV/DIVU/REM/REMU (W-variants under DIV_UNIT_WORD_OPS_EN)
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic        is_word_i,
  input  logic [63:0] dividend_i,
  input  logic [63:0] divisor_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [63:0] result_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] quo_q, quo_d;
  logic [63:0] rem_q, rem_d;
  logic [63:0] dvs_q, dvs_d;
  logic [63:0] result_q, result_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        isrem_q, isrem_d;
  logic        word_q, word_d;

  logic        word_en;
`ifdef DIV_UNIT_WORD_OPS_EN
  assign word_en = is_word_i;
`else
  logic        unused_is_word;
  assign word_en        = 1'b0;
  assign unused_is_word = is_word_i;
`endif

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  logic        signed_op, rem_op, dvd_neg, dvs_neg, div_zero, sgn_ovf;
  logic [63:0] dvd_ext, dvs_ext, dvd_abs, dvs_abs, most_neg, spec_val, spec_res;

  // Decode the incoming request: extend operands, take magnitudes, detect the
  // divide-by-zero and signed-overflow shortcuts that skip the iteration.
  always_comb begin
    signed_op = ~op_i[0];
    rem_op    = op_i[1];
    if (word_en) begin
      dvd_ext  = signed_op ? sext32(dividend_i[31:0]) : {32'b0, dividend_i[31:0]};
      dvs_ext  = signed_op ? sext32(divisor_i[31:0])  : {32'b0, divisor_i[31:0]};
      most_neg = 64'hFFFF_FFFF_8000_0000;
    end else begin
      dvd_ext  = dividend_i;
      dvs_ext  = divisor_i;
      most_neg = 64'h8000_0000_0000_0000;
    end
    dvd_neg  = signed_op & dvd_ext[63];
    dvs_neg  = signed_op & dvs_ext[63];
    dvd_abs  = dvd_neg ? -dvd_ext : dvd_ext;
    dvs_abs  = dvs_neg ? -dvs_ext : dvs_ext;
    div_zero = (dvs_ext == 64'd0);
    sgn_ovf  = signed_op && (dvd_ext == most_neg) && (dvs_ext == {64{1'b1}});
    if (div_zero) begin
      spec_val = rem_op ? dvd_ext : {64{1'b1}};
    end else begin
      spec_val = rem_op ? 64'd0 : dvd_ext;
    end
    spec_res = word_en ? sext32(spec_val[31:0]) : spec_val;
  end

  logic [64:0] rem_shift;
  logic        fits;
  logic [63:0] rem_step, quo_step, q_fin, r_fin, sel_res, fin_res;

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract the divisor if it fits, and shift the outcome into
  // the quotient. Also form the signed, width-adjusted final result.
  always_comb begin
    rem_shift = {rem_q, quo_q[63]};
    fits      = (rem_shift >= {1'b0, dvs_q});
    rem_step  = fits ? (rem_shift[63:0] - dvs_q) : rem_shift[63:0];
    quo_step  = {quo_q[62:0], fits};
    q_fin     = negq_q ? -quo_step : quo_step;
    r_fin     = negr_q ? -rem_step : rem_step;
    sel_res   = isrem_q ? r_fin : q_fin;
    fin_res   = word_q ? sext32(sel_res[31:0]) : sel_res;
  end

  // Next-state and output logic; flush overrides everything and leaves the
  // published result untouched.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    isrem_d  = isrem_q;
    word_d   = word_q;
    stall_o  = 1'b0;
    valid_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          stall_o = 1'b1;
          negq_d  = dvd_neg ^ dvs_neg;
          negr_d  = dvd_neg;
          isrem_d = rem_op;
          word_d  = word_en;
          cnt_d   = 6'd0;
          rem_d   = 64'd0;
          dvs_d   = dvs_abs;
          quo_d   = word_en ? {dvd_abs[31:0], 32'b0} : dvd_abs;
          if (div_zero || sgn_ovf) begin
            result_d = spec_res;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        stall_o = 1'b1;
        quo_d   = quo_step;
        rem_d   = rem_step;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == (word_q ? 6'd31 : 6'd63)) begin
          result_d = fin_res;
          state_d  = DONE;
        end
      end
      DONE: begin
        valid_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  assign result_o = result_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      quo_q    <= 64'd0;
      rem_q    <= 64'd0;
      dvs_q    <= 64'd0;
      result_q <= 64'd0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      isrem_q  <= 1'b0;
      word_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      isrem_q  <= isrem_d;
      word_q   <= word_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic        is_word_i;
  logic [63:0] dividend_i;
  logic [63:0] divisor_i;
  logic        stall_o;
  logic        valid_o;
  logic [63:0] result_o;

  int vectors;
  int miscompares;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .is_word_i  (is_word_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .stall_o    (stall_o),
    .valid_o    (valid_o),
    .result_o   (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge while the unit is idle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic word,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat, input int noise);
    int   lat;
    logic stall_hi;
    op_i       = op;
    is_word_i  = word;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    #1 stall_hi = stall_o;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat <= noise) begin
        start_i    = 1'b1;
        dividend_i = 64'h1234 + 64'(lat);
        divisor_i  = 64'd3;
      end else begin
        start_i = 1'b0;
      end
      #1;
      if (!valid_o) stall_hi = stall_hi & stall_o;
    end while (!valid_o && lat < 200);
    start_i = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, result_o, exp_res);
    chk({tag, " stall_busy"}, {63'd0, stall_hi}, 64'd1);
    chk({tag, " stall_done"}, {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    #1;
    chk({tag, " valid_once"}, {63'd0, valid_o}, 64'd0);
    chk({tag, " result_hold"}, result_o, exp_res);
  endtask

  initial begin
    int n_valid;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    flush_i     = 1'b0;
    start_i     = 1'b0;
    op_i        = 2'b00;
    is_word_i   = 1'b0;
    dividend_i  = 64'd0;
    divisor_i   = 64'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset valid", {63'd0, valid_o}, 64'd0);
    chk("reset result", result_o, 64'd0);
    chk("reset stall", {63'd0, stall_o}, 64'd0);

    run_op("div 100/-7", OP_DIV, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 65, 0);
    run_op("rem -100/7", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
    run_op("remu ones/16", OP_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'hF, 65, 0);
    run_op("divu 5/0", OP_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("rem ovf", OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
    run_op("div ovf", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 0);
    run_op("remu 7/0", OP_REMU, 1'b0, 64'd7, 64'd0, 64'd7, 1, 0);
    run_op("div -7/2 start_in_calc", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 6);
    run_op("rem -7/2", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("divu ones/ones", OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65, 0);

    // Flush ten cycles into a divide, restart immediately afterwards.
    op_i       = OP_DIV;
    is_word_i  = 1'b0;
    dividend_i = 64'd100;
    divisor_i  = 64'hFFFF_FFFF_FFFF_FFF9;
    start_i    = 1'b1;
    repeat (9) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    @(negedge clk);
    flush_i = 1'b1;
    #1 chk("flush cycle valid", {63'd0, valid_o}, 64'd0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("after flush valid", {63'd0, valid_o}, 64'd0);
    chk("after flush result", result_o, 64'd1);
    chk("after flush idle stall", {63'd0, stall_o}, 64'd0);
    run_op("divu 9/3 after flush", OP_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 65, 0);

    // Flush together with start: the request is dropped.
    op_i       = OP_DIVU;
    dividend_i = 64'd50;
    divisor_i  = 64'd5;
    start_i    = 1'b1;
    flush_i    = 1'b1;
    #1 chk("flush+start stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    n_valid = 0;
    repeat (70) begin
      @(negedge clk);
      #1 if (valid_o) n_valid++;
    end
    chk("flush+start no valid", 64'(n_valid), 64'd0);
    chk("flush+start result", result_o, 64'd3);

    // Reset in the middle of an iteration.
    op_i       = OP_DIVU;
    dividend_i = 64'd1000;
    divisor_i  = 64'd10;
    start_i    = 1'b1;
    repeat (20) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid-calc rst valid", {63'd0, valid_o}, 64'd0);
    chk("mid-calc rst result", result_o, 64'd0);
    chk("mid-calc rst stall", {63'd0, stall_o}, 64'd0);
    rst = 1'b0;
    n_valid = 0;
    repeat (70) begin
      @(negedge clk);
      #1 if (valid_o) n_valid++;
    end
    chk("mid-calc rst no valid", 64'(n_valid), 64'd0);
    run_op("div -7/2 after rst", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);

`ifdef DIV_UNIT_WORD_OPS_EN
    run_op("divw fff8/2", OP_DIV, 1'b1, 64'h0000_0000_FFFF_FFF8, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 33, 0);
    run_op("remuw 1_7/4", OP_REMU, 1'b1, 64'h0000_0001_0000_0007, 64'd4, 64'd3, 33, 0);
    run_op("divuw ffffffff/1", OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
    run_op("remw div0", OP_REM, 1'b1, 64'h0000_0001_8000_0005, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8000_0005, 1, 0);
    run_op("divw ovf", OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
`else
    run_op("word ignored", OP_DIV, 1'b1, 64'h0000_0000_FFFF_FFF8, 64'd2, 64'h0000_0000_7FFF_FFFC, 65, 0);
    run_op("word ignored remu", OP_REMU, 1'b1, 64'h0000_0001_0000_0007, 64'd4, 64'd3, 65, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameters: none; datapath width fixed at 64 bits.
REQ-002 clk  input  1  one clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset is synchronous and active-high.
REQ-004 flush_i  input  1  abort in-flight operation (branch/hazard flush of EX).
REQ-005 start_i  input  1  request a new divide; driven from ID/EX decode of an M-extension divide.
REQ-006 op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 is_word_i  input  1  W-variant (DIVW/DIVUW/REMW/REMUW).
REQ-008 dividend_i  input  64  forwarded rs1 value.
REQ-009 divisor_i  input  64  forwarded rs2 value.
REQ-010 stall_o  output  1  freeze IF/ID and ID/EX while the divide is in flight.
REQ-011 valid_o  output  1  result_o is valid this cycle.
REQ-012 result_o  output  64  quotient or remainder.

Function
REQ-013 FSM states: IDLE, CALC, DONE; any unused encoding returns to IDLE on the next edge.
REQ-014 IDLE and start_i=1 with no flush: latch operands, op, and width; go to CALC, or go to DONE directly for special cases (REQ-019, REQ-020).
REQ-015 CALC: one restoring radix-2 step per cycle on absolute values; 64 steps (32 if word); then go to DONE.
REQ-016 DONE: valid_o=1 for exactly one cycle, then go to IDLE; result_o holds its value until the next accepted start.
REQ-017 Latency: start accepted in cycle N -> valid_o in cycle N+65 (N+33 word); special cases valid in N+1.
REQ-018 stall_o = (IDLE and start_i and not flush_i) or CALC; combinational; low in DONE so the instruction advances with the result.
REQ-019 Divisor zero: quotient = all ones; remainder = dividend (word: low 32 bits sign-extended).
REQ-020 Signed overflow (DIV/REM, dividend = most negative value, divisor = -1): quotient = dividend; remainder = 0; word variant uses 0x80000000.
REQ-021 Signed ops: quotient negated when operand signs differ; remainder takes the sign of the dividend; truncation toward zero.
REQ-022 Word ops: operands are the low 32 bits, sign-extended (signed ops) or zero-extended (unsigned ops); the 32-bit result is sign-extended to 64 bits for all four ops.
REQ-023 start_i is ignored in CALC and DONE.
REQ-024 flush_i=1 in any state: go to IDLE next cycle; valid_o=0 next cycle; result_o unchanged; flush wins over a simultaneous start.

Reset
REQ-025 rst=1: state=IDLE, valid_o=0, result_o=0, step counter=0, internal quotient/remainder registers=0.
REQ-026 rst mid-CALC aborts the operation; no valid_o is produced for it.

Configuration
REQ-027 Macro DIV_UNIT_WORD_OPS_EN.
REQ-028 Defined: is_word_i is honoured per REQ-007, REQ-017, REQ-020, and REQ-022.
REQ-029 Undefined: is_word_i port is present but ignored (treated as 0); all ops take 64 steps; no word logic is synthesised.

Verification
REQ-030 DIV 100 / -7 -> result_o=0xFFFFFFFFFFFFFFF2 (-14), valid_o at N+65, stall_o high N..N+64.
REQ-031 REM -100 / 7 -> result_o=0xFFFFFFFFFFFFFFFE (-2); REMU 0xFFFFFFFFFFFFFFFF / 16 -> result_o=0xF.
REQ-032 DIVU 5 / 0 -> result_o=all ones at N+1; REM 0x8000000000000000 / -1 -> result_o=0 at N+1.
REQ-033 (DIV_UNIT_WORD_OPS_EN) DIVW 0x00000000_FFFFFFF8 / 2 -> result_o=0xFFFFFFFFFFFFFFFC at N+33; REMUW 0x1_00000007 / 4 -> result_o=3.
REQ-034 flush_i at N+10 of a DIV -> IDLE at N+11, no valid_o; start at N+11 with 9/3 DIVU -> result_o=3 at N+76.
REQ-035 rst asserted mid-CALC -> valid_o=0, result_o=0, stall_o=0 the next cycle.
